// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares one tone generator among the auto-play sequencer,
// the free-play keyboard and a one-shot alert beep. Priority is
// beep > keyboard > auto. Every change of owner passes through a silent gap,
// and auto-play is told to pause its note timing while it is pre-empted.
module buzzer_arbiter #(
    parameter int unsigned NOTE_W      = 5,
    parameter int unsigned GAP_CYCLES  = 100000,
    parameter int unsigned BEEP_CYCLES = 20000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              auto_req,
    input  logic [NOTE_W-1:0] auto_note,
    input  logic              key_req,
    input  logic [NOTE_W-1:0] key_note,
    input  logic              beep_pulse,
    input  logic [NOTE_W-1:0] beep_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic [1:0]        owner,
    output logic              auto_pause,
    output logic              beep_busy
);

    typedef enum logic [2:0] {IDLE, GAP, S_AUTO, S_KEY, S_BEEP} state_t;

    // Owner codes double as priority ranks: a larger code wins.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_AUTO = 2'd1;
    localparam logic [1:0] OWN_KEY  = 2'd2;
    localparam logic [1:0] OWN_BEEP = 2'd3;

    // Terminal counts: the gap and the beep each last exactly N cycles.
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] BEEP_LAST = 32'(BEEP_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic [1:0]        gap_target;
    logic [1:0]        next_target;
    logic [31:0]       gap_cnt;
    logic [31:0]       beep_cnt;
    logic              beep_pending;
    logic [NOTE_W-1:0] beep_note_q;

    logic              beep_capture;
    logic              beep_req;
    logic [1:0]        winner;
    logic              target_live;
    logic [1:0]        gap_pick;
    logic [NOTE_W-1:0] beep_note_eff;

    function automatic state_t serve_state(input logic [1:0] code);
        case (code)
            OWN_AUTO: serve_state = S_AUTO;
            OWN_KEY:  serve_state = S_KEY;
            OWN_BEEP: serve_state = S_BEEP;
            default:  serve_state = IDLE;
        endcase
    endfunction

    // A new beep is accepted only while no beep is pending or sounding; a
    // pulse counts as a request in the very cycle it arrives.
    assign beep_capture  = beep_pulse && !beep_busy;
    assign beep_req      = beep_pending || beep_capture;
    assign beep_note_eff = beep_capture ? beep_note : beep_note_q;

    // Highest-priority live requester, and whether the gap target still wants the buzzer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        winner      = OWN_NONE;
        target_live = 1'b0;
        if (beep_req)      winner = OWN_BEEP;
        else if (key_req)  winner = OWN_KEY;
        else if (auto_req) winner = OWN_AUTO;
        case (gap_target)
            OWN_AUTO: target_live = auto_req;
            OWN_KEY:  target_live = key_req;
            OWN_BEEP: target_live = beep_req;
            default:  target_live = 1'b0;
        endcase
        // Keep the target unless it dropped out or something higher arrived.
        gap_pick = (target_live && gap_target >= winner) ? gap_target : winner;
    end

    // Next-state and gap-target selection.
    always_comb begin
        next_state  = state;
        next_target = gap_target;
        case (state)
            IDLE: begin
                next_state = serve_state(winner);
            end
            S_AUTO: begin
                // A dropping auto request wins over a simultaneous arrival.
                if (!auto_req) begin
                    next_state = IDLE;
                end else if (beep_req) begin
                    next_state  = GAP;
                    next_target = OWN_BEEP;
                end else if (key_req) begin
                    next_state  = GAP;
                    next_target = OWN_KEY;
                end
            end
            S_KEY: begin
                if (beep_req) begin
                    next_state  = GAP;
                    next_target = OWN_BEEP;
                end else if (!key_req) begin
                    if (auto_req) begin
                        next_state  = GAP;
                        next_target = OWN_AUTO;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            S_BEEP: begin
                if (beep_cnt == BEEP_LAST) begin
                    if (key_req) begin
                        next_state  = GAP;
                        next_target = OWN_KEY;
                    end else if (auto_req) begin
                        next_state  = GAP;
                        next_target = OWN_AUTO;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = serve_state(gap_pick);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counters, beep latch and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state        <= IDLE;
            gap_target   <= OWN_NONE;
            gap_cnt      <= '0;
            beep_cnt     <= '0;
            beep_pending <= 1'b0;
            beep_note_q  <= '0;
            note_out     <= '0;
            note_valid   <= 1'b0;
            owner        <= OWN_NONE;
            auto_pause   <= 1'b0;
            beep_busy    <= 1'b0;
        end else begin
            state      <= next_state;
            gap_target <= next_target;

            // Both counters restart on entry and hold at their terminal count.
            if (next_state == GAP && state != GAP) begin
                gap_cnt <= '0;
            end else if (state == GAP && gap_cnt != GAP_LAST) begin
                gap_cnt <= gap_cnt + 32'd1;
            end

            if (next_state == S_BEEP && state != S_BEEP) begin
                beep_cnt <= '0;
            end else if (state == S_BEEP && beep_cnt != BEEP_LAST) begin
                beep_cnt <= beep_cnt + 32'd1;
            end

            // The pending flag is consumed when the beep starts sounding.
            beep_pending <= beep_req && (next_state != S_BEEP);
            if (beep_capture) begin
                beep_note_q <= beep_note;
            end
            beep_busy  <= beep_req || (next_state == S_BEEP);
            auto_pause <= auto_req && (next_state != S_AUTO);

            note_out   <= '0;
            note_valid <= 1'b0;
            owner      <= OWN_NONE;
            case (next_state)
                S_AUTO: begin
                    note_out   <= auto_note;
                    note_valid <= 1'b1;
                    owner      <= OWN_AUTO;
                end
                S_KEY: begin
                    note_out   <= key_note;
                    note_valid <= 1'b1;
                    owner      <= OWN_KEY;
                end
                S_BEEP: begin
                    note_out   <= beep_note_eff;
                    note_valid <= 1'b1;
                    owner      <= OWN_BEEP;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
